// File: rtl/fetch_queue_if.sv
// Fetch/decode/redirect signal bundle for fetch_queue.
// Handshake: a word moves on d_* when d_valid && d_ready at a clock edge; fetch
// holds f_pc/f_insn stable while f_stall is high, and f_pcsel overrides f_stall.
interface fetch_queue_if;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_insn;
    logic        f_stall;
    logic        f_pcsel;
    logic [31:0] f_target;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_insn;
    logic        d_ready;
    logic        redir_valid;
    logic [31:0] redir_pc;

    modport slave (
        input  f_valid, f_pc, f_insn, d_ready, redir_valid, redir_pc,
        output f_stall, f_pcsel, f_target, d_valid, d_pc, d_insn
    );

    modport master (
        output f_valid, f_pc, f_insn, d_ready, redir_valid, redir_pc,
        input  f_stall, f_pcsel, f_target, d_valid, d_pc, d_insn
    );
endinterface

// File: rtl/fetch_queue.sv
// Decode-side show-ahead FIFO for the fetch stream, with stall back-pressure
// and a two-state redirect FSM that flushes and discards wrong-path words.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    fetch_queue_if.slave     bus,
    output logic             dbg_redirect,
    output logic [PTR_W:0]   dbg_count
);
    typedef enum logic {ST_RUN = 1'b0, ST_REDIRECT = 1'b1} state_t;

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0]    NOP  = 32'h0000_0013;

    state_t             state_q, state_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [31:0]        f_target_q, f_target_d;
    logic [31:0]        pc_mem_q [DEPTH];
    logic [31:0]        pc_mem_d [DEPTH];
    logic [31:0]        insn_mem_q [DEPTH];
    logic [31:0]        insn_mem_d [DEPTH];

    logic run;
    logic not_empty;
    logic enq;
    logic deq;

    assign run       = (state_q == ST_RUN);
    assign not_empty = (count_q != '0);

    // Outputs depend only on registered state, so d_ready never reaches f_stall.
    assign bus.d_valid  = not_empty && run;
    assign bus.f_stall  = (count_q == FULL) && run;
    assign bus.f_pcsel  = (state_q == ST_REDIRECT);
    assign bus.f_target = f_target_q;
    assign bus.d_pc     = not_empty ? pc_mem_q[rptr_q]   : 32'h0;
    assign bus.d_insn   = not_empty ? insn_mem_q[rptr_q] : NOP;

    assign enq = bus.f_valid && !bus.f_stall && run && !bus.redir_valid;
    assign deq = bus.d_valid && bus.d_ready;

    assign dbg_redirect = (state_q == ST_REDIRECT);
    assign dbg_count    = count_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        f_target_d = f_target_q;
        pc_mem_d   = pc_mem_q;
        insn_mem_d = insn_mem_q;

        if (enq) begin
            pc_mem_d[wptr_q]   = bus.f_pc;
            insn_mem_d[wptr_q] = bus.f_insn;
            wptr_d             = wptr_q + PTR_W'(1);
        end
        if (deq) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_RUN: begin
                if (bus.redir_valid) begin
                    // Flush overrides any handshake made in the same cycle.
                    state_d    = ST_REDIRECT;
                    count_d    = '0;
                    wptr_d     = '0;
                    rptr_d     = '0;
                    f_target_d = bus.redir_pc & 32'hFFFF_FFFC;
                end
            end
            ST_REDIRECT: begin
                if (bus.redir_valid) begin
                    f_target_d = bus.redir_pc & 32'hFFFF_FFFC;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            f_target_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            f_target_q <= f_target_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        insn_mem_q <= insn_mem_d;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a cycle-by-cycle vector table, a modelled
// fetch stream with an in-order scoreboard, and a redirect-target monitor.
module tb_fetch_queue;
    logic       clk;
    logic       rst;
    logic       dbg_redirect;
    logic [2:0] dbg_count;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .dbg_redirect (dbg_redirect),
        .dbg_count    (dbg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fv;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        dr;
        logic        rv;
        logic [31:0] rpc;
        logic        e_dv;
        logic [31:0] e_pc;
        logic [31:0] e_insn;
        logic        e_stall;
        logic        e_pcsel;
        logic [31:0] e_tgt;
        logic [2:0]  e_cnt;
        logic        e_redir;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          checks;
    int          errors;
    logic        sb_on;
    logic        armed;
    logic [31:0] sb_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.f_valid     = 1'b0;
        bus.f_pc        = 32'h0;
        bus.f_insn      = 32'h0;
        bus.d_ready     = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 32'h0;
    endtask

    // In-order scoreboard on every decode handshake while a stream test runs.
    always @(posedge clk) begin
        if (sb_on && !rst && bus.d_valid && bus.d_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got pc %h expected no word", bus.d_pc);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_pc", bus.d_pc, sb_exp);
                chk("sb_insn", bus.d_insn, 32'h1000_0000 | sb_exp);
            end
        end
    end

    // After a redirect, the first word accepted must be the target word.
    always @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
        end else begin
            if (armed && !dbg_redirect && bus.f_valid && !bus.f_stall && !bus.redir_valid) begin
                chk("redir_first_pc", bus.f_pc, bus.f_target);
                armed <= 1'b0;
            end
            if (bus.f_pcsel) armed <= 1'b1;
        end
    end

    // Fetch model: presents base+4k, advances only when the model says the word
    // was taken; the model count must track the DUT every cycle.
    task automatic run_stream(input string name, input int n, input logic [31:0] base,
                              input logic [31:0] rdy_pat);
        int  k;
        int  m_count;
        logic enq_m;
        logic deq_m;
        logic done;
        k = 0;
        m_count = 0;
        done = 1'b0;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
        sb_on = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            bus.f_valid     = (k < n);
            bus.f_pc        = base + 32'(4 * k);
            bus.f_insn      = 32'h1000_0000 | (base + 32'(4 * k));
            bus.d_ready     = (c < 32) ? rdy_pat[c] : 1'b1;
            bus.redir_valid = 1'b0;
            enq_m = bus.f_valid && (m_count != 4);
            deq_m = (m_count != 0) && bus.d_ready;
            @(posedge clk);
            #1;
            if (enq_m) k++;
            m_count = m_count + (enq_m ? 1 : 0) - (deq_m ? 1 : 0);
            chk($sformatf("%s.c%0d.count", name, c), 32'(dbg_count), 32'(m_count));
            chk($sformatf("%s.c%0d.stall", name, c), 32'(bus.f_stall), 32'(m_count == 4));
            chk($sformatf("%s.c%0d.d_valid", name, c), 32'(bus.d_valid), 32'(m_count != 0));
            if (k == n && m_count == 0) done = 1'b1;
        end
        sb_on = 1'b0;
        drive_idle();
        chk($sformatf("%s.finished", name), 32'(done), 32'd1);
        chk($sformatf("%s.sb_left", name), 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sb_on  = 1'b0;
        rst    = 1'b1;
        drive_idle();

        //          rst   fv    pc           insn         dr    rv    rpc          | dv    pc           insn         stall pcsel tgt          cnt   redir
        vecs.push_back('{1'b1, 1'b1, 32'h100,  32'hDEAD, 1'b1, 1'b1, 32'h44,   1'b0, 32'h0,  32'h13,  1'b0, 1'b0, 32'h0,    3'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0,    32'hA,    1'b1, 1'b0, 32'h0,    1'b1, 32'h0,  32'hA,   1'b0, 1'b0, 32'h0,    3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h4,    32'hB,    1'b1, 1'b0, 32'h0,    1'b1, 32'h4,  32'hB,   1'b0, 1'b0, 32'h0,    3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h8,    32'hC,    1'b1, 1'b0, 32'h0,    1'b1, 32'h8,  32'hC,   1'b0, 1'b0, 32'h0,    3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  32'h13,  1'b0, 1'b0, 32'h0,    3'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h20,   32'h120,  1'b0, 1'b0, 32'h0,    1'b1, 32'h20, 32'h120, 1'b0, 1'b0, 32'h0,    3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h24,   32'h124,  1'b0, 1'b0, 32'h0,    1'b1, 32'h20, 32'h120, 1'b0, 1'b0, 32'h0,    3'd2, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h28,   32'h128,  1'b0, 1'b0, 32'h0,    1'b1, 32'h20, 32'h120, 1'b0, 1'b0, 32'h0,    3'd3, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h2C,   32'h12C,  1'b0, 1'b1, 32'h43,   1'b0, 32'h0,  32'h13,  1'b0, 1'b1, 32'h40,   3'd0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h30,   32'h130,  1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  32'h13,  1'b0, 1'b0, 32'h40,   3'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h40,   32'h140,  1'b0, 1'b0, 32'h0,    1'b1, 32'h40, 32'h140, 1'b0, 1'b0, 32'h40,   3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h44,   32'h144,  1'b1, 1'b0, 32'h0,    1'b1, 32'h44, 32'h144, 1'b0, 1'b0, 32'h40,   3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h48,   32'h148,  1'b1, 1'b1, 32'h40,   1'b0, 32'h0,  32'h13,  1'b0, 1'b1, 32'h40,   3'd0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h50,   32'h150,  1'b1, 1'b1, 32'h81,   1'b0, 32'h0,  32'h13,  1'b0, 1'b1, 32'h80,   3'd0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h44,   32'h144,  1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  32'h13,  1'b0, 1'b0, 32'h80,   3'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h80,   32'h180,  1'b0, 1'b0, 32'h0,    1'b1, 32'h80, 32'h180, 1'b0, 1'b0, 32'h80,   3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  32'h13,  1'b0, 1'b0, 32'h80,   3'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b1, 32'h123C, 1'b0, 32'h0,  32'h13,  1'b0, 1'b1, 32'h123C, 3'd0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h0,    32'h0,    1'b0, 1'b1, 32'h500,  1'b0, 32'h0,  32'h13,  1'b0, 1'b0, 32'h0,    3'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'h0,  32'h13,  1'b0, 1'b0, 32'h0,    3'd0, 1'b0});

        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst             = vecs[i].rst;
            bus.f_valid     = vecs[i].fv;
            bus.f_pc        = vecs[i].pc;
            bus.f_insn      = vecs[i].insn;
            bus.d_ready     = vecs[i].dr;
            bus.redir_valid = vecs[i].rv;
            bus.redir_pc    = vecs[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.d_valid", i), 32'(bus.d_valid), 32'(vecs[i].e_dv));
            chk($sformatf("v%0d.d_pc", i), bus.d_pc, vecs[i].e_pc);
            chk($sformatf("v%0d.d_insn", i), bus.d_insn, vecs[i].e_insn);
            chk($sformatf("v%0d.f_stall", i), 32'(bus.f_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d.f_pcsel", i), 32'(bus.f_pcsel), 32'(vecs[i].e_pcsel));
            chk($sformatf("v%0d.f_target", i), bus.f_target, vecs[i].e_tgt);
            chk($sformatf("v%0d.count", i), 32'(dbg_count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d.state", i), 32'(dbg_redirect), 32'(vecs[i].e_redir));
        end
        drive_idle();
        rst = 1'b0;

        // Fill to full with decode stalled, one-cycle drain, refill, then drain.
        run_stream("stall", 6, 32'h0, 32'hFFFF_FE40);
        // Fill to full, then decode always ready: full-cycle deq then steady enq+deq.
        run_stream("full_flow", 8, 32'h200, 32'hFFFF_FFF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
